// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-subset control FSM: opcodes, funct codes, states and
// datapath select codes.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_SLT = 6'h2a;
  localparam logic [5:0] F_JR  = 6'h08;

  localparam int unsigned ALU_ADD = 0;
  localparam int unsigned ALU_SUB = 1;
  localparam int unsigned ALU_XOR = 2;
  localparam int unsigned ALU_SLT = 3;

  localparam int unsigned SRCB_ZERO = 0;
  localparam int unsigned SRCB_IMM  = 1;
  localparam int unsigned SRCB_REGB = 2;
  localparam int unsigned SRCB_FOUR = 3;
  localparam int unsigned SRCB_REGA = 4;

  localparam logic [1:0] PCSRC_HOLD = 2'd0;
  localparam logic [1:0] PCSRC_ALU  = 2'd1;
  localparam logic [1:0] PCSRC_JUMP = 2'd2;

  localparam int unsigned BR_NONE = 0;
  localparam int unsigned BR_EQ   = 1;
  localparam int unsigned BR_NE   = 2;

  typedef enum logic [4:0] {
    StIf        = 5'd0,
    StIdDec     = 5'd1,
    StIdJ       = 5'd2,
    StIdJal     = 5'd3,
    StIdBr      = 5'd4,
    StExBeq     = 5'd5,
    StExBne     = 5'd6,
    StExMemAddi = 5'd7,
    StExXori    = 5'd8,
    StExAdd     = 5'd9,
    StExSub     = 5'd10,
    StExSlt     = 5'd11,
    StExJr      = 5'd12,
    StMemLw     = 5'd13,
    StMemSw     = 5'd14,
    StWbLw      = 5'd15,
    StWbImm     = 5'd16,
    StWbR       = 5'd17,
    StTrap      = 5'd18
  } state_e;

  // ALU operation for a legal R-type arithmetic funct; JR and unknown codes fall back to add.
  function automatic int unsigned rtype_alu(input logic [5:0] funct);
    int unsigned op;
    case (funct)
      F_SUB:   op = ALU_SUB;
      F_SLT:   op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_v2_if.sv
// Instruction/memory handshake and datapath control bundle between the control FSM and the datapath.
interface mc_ctrl_fsm_v2_if #(
  parameter int unsigned ALUOP_W  = 3,
  parameter int unsigned SRCB_W   = 3,
  parameter int unsigned BRANCH_W = 4
);

  logic [31:0]         instruction;
  logic                mem_ready;
  logic                mem_req;
  logic                PC_WE;
  logic                Mem_WE;
  logic                IR_WE;
  logic                ALUSrcA;
  logic                Dst;
  logic                RegIn;
  logic                Reg_WE;
  logic                JAL;
  logic [1:0]          PCSrc;
  logic [SRCB_W-1:0]   ALUSrcB;
  logic [ALUOP_W-1:0]  ALUop;
  logic [BRANCH_W-1:0] Branch;
  logic                trap;
  logic [4:0]          state_o;

  modport master (
    input  instruction, mem_ready,
    output mem_req, PC_WE, Mem_WE, IR_WE, ALUSrcA, Dst, RegIn, Reg_WE, JAL,
           PCSrc, ALUSrcB, ALUop, Branch, trap, state_o
  );

  modport slave (
    output instruction, mem_ready,
    input  mem_req, PC_WE, Mem_WE, IR_WE, ALUSrcA, Dst, RegIn, Reg_WE, JAL,
           PCSrc, ALUSrcB, ALUop, Branch, trap, state_o
  );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decode: picks the state that follows ID_DEC and flags illegal encodings.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output state_e     dispatch,
  output logic       illegal
);

  always_comb begin
    dispatch = StIf;
    illegal  = 1'b0;
    case (opcode)
      OP_J:                   dispatch = StIdJ;
      OP_JAL:                 dispatch = StIdJal;
      OP_BEQ, OP_BNE:         dispatch = StIdBr;
      OP_LW, OP_SW, OP_ADDI:  dispatch = StExMemAddi;
      OP_XORI:                dispatch = StExXori;
      // funct is only meaningful for opcode 0; any other opcode ignores it entirely
      OP_RTYPE: begin
        case (funct)
          F_ADD:   dispatch = StExAdd;
          F_SUB:   dispatch = StExSub;
          F_SLT:   dispatch = StExSlt;
          F_JR:    dispatch = StExJr;
          default: illegal  = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm_v2.sv
// Multicycle MIPS-subset control FSM with mem_req/mem_ready wait states and a memory wait counter.
// Define CTRL_TRAP_EN to route illegal instructions and memory timeouts to a sticky TRAP state.
module mc_ctrl_fsm_v2
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W     = 3,
  parameter int unsigned SRCB_W      = 3,
  parameter int unsigned BRANCH_W    = 4,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  mc_ctrl_fsm_v2_if.master   bus
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  state_e          state_q, state_d;
  state_e          dispatch;
  logic            illegal;
  logic [CntW-1:0] wait_q, wait_d;
  logic [5:0]      opcode, funct;
  logic            in_wait;

  assign opcode  = bus.instruction[31:26];
  assign funct   = bus.instruction[5:0];
  assign in_wait = (state_q == StIf) || (state_q == StMemLw) || (state_q == StMemSw);

  mc_ctrl_decode u_decode (
    .opcode   (opcode),
    .funct    (funct),
    .dispatch (dispatch),
    .illegal  (illegal)
  );

  // Counter is zero outside wait states, so every wait state is entered with a clean count.
  always_comb begin
    wait_d = '0;
    if (in_wait && !bus.mem_ready) begin
      wait_d = (wait_q == CntW'(MEM_TIMEOUT)) ? wait_q : wait_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIf:        if (bus.mem_ready) state_d = StIdDec;
      StIdDec: begin
        if (illegal) begin
`ifdef CTRL_TRAP_EN
          state_d = StTrap;
`else
          state_d = StIf;
`endif
        end else begin
          state_d = dispatch;
        end
      end
      StIdBr:      state_d = (opcode == OP_BNE) ? StExBne : StExBeq;
      StExMemAddi: begin
        case (opcode)
          OP_LW:   state_d = StMemLw;
          OP_SW:   state_d = StMemSw;
          default: state_d = StWbImm;
        endcase
      end
      StExXori:                   state_d = StWbImm;
      StExAdd, StExSub, StExSlt:  state_d = StWbR;
      StMemLw:     if (bus.mem_ready) state_d = StWbLw;
      StMemSw:     if (bus.mem_ready) state_d = StIf;
      StIdJ, StIdJal, StExBeq, StExBne, StExJr, StWbLw, StWbImm, StWbR: state_d = StIf;
`ifdef CTRL_TRAP_EN
      StTrap:      state_d = StTrap;
`endif
      default:     state_d = StIf;
    endcase
`ifdef CTRL_TRAP_EN
    // A completion on the saturating cycle still wins; only a further stall times out.
    if (in_wait && !bus.mem_ready && (wait_q == CntW'(MEM_TIMEOUT))) state_d = StTrap;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIf;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Everything is held at zero during reset so an aborted access never sees a write strobe.
  always_comb begin
    bus.mem_req = 1'b0;
    bus.PC_WE   = 1'b0;
    bus.Mem_WE  = 1'b0;
    bus.IR_WE   = 1'b0;
    bus.ALUSrcA = 1'b0;
    bus.Dst     = 1'b0;
    bus.RegIn   = 1'b0;
    bus.Reg_WE  = 1'b0;
    bus.JAL     = 1'b0;
    bus.PCSrc   = PCSRC_HOLD;
    bus.ALUSrcB = SRCB_W'(SRCB_ZERO);
    bus.ALUop   = ALUOP_W'(ALU_ADD);
    bus.Branch  = BRANCH_W'(BR_NONE);
    bus.trap    = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        StIf: begin
          bus.mem_req = 1'b1;
          bus.ALUSrcB = SRCB_W'(SRCB_FOUR);
          bus.PCSrc   = PCSRC_ALU;
          bus.PC_WE   = bus.mem_ready;
          bus.IR_WE   = bus.mem_ready;
        end
        StIdJ, StIdJal: begin
          bus.PC_WE  = 1'b1;
          bus.PCSrc  = PCSRC_JUMP;
          bus.JAL    = (state_q == StIdJal);
          bus.RegIn  = (state_q == StIdJal);
          bus.Reg_WE = (state_q == StIdJal);
        end
        StExBeq, StExBne: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_W'(SRCB_REGB);
          bus.ALUop   = ALUOP_W'(ALU_SUB);
          bus.Branch  = (state_q == StExBne) ? BRANCH_W'(BR_NE) : BRANCH_W'(BR_EQ);
        end
        StExJr: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_W'(SRCB_REGA);
          bus.PCSrc   = PCSRC_ALU;
          bus.PC_WE   = 1'b1;
        end
        // IR is stable after fetch, so the opcode recreates the EX ALU setup during WB.
        StExMemAddi, StExXori, StWbImm: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_W'(SRCB_IMM);
          bus.ALUop   = (opcode == OP_XORI) ? ALUOP_W'(ALU_XOR) : ALUOP_W'(ALU_ADD);
          bus.RegIn   = (state_q == StWbImm);
          bus.Reg_WE  = (state_q == StWbImm);
        end
        StExAdd, StExSub, StExSlt, StWbR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_W'(SRCB_REGB);
          bus.ALUop   = ALUOP_W'(rtype_alu(funct));
          bus.Dst     = (state_q == StWbR);
          bus.RegIn   = (state_q == StWbR);
          bus.Reg_WE  = (state_q == StWbR);
        end
        StMemLw:  bus.mem_req = 1'b1;
        StMemSw: begin
          bus.mem_req = 1'b1;
          bus.Mem_WE  = bus.mem_ready;
        end
        StWbLw:   bus.Reg_WE = 1'b1;
`ifdef CTRL_TRAP_EN
        StTrap:   bus.trap = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign bus.state_o = reset_n ? state_q : 5'd0;

endmodule

// File: tb/tb_mc_ctrl_fsm_v2.sv
// Directed bench for mc_ctrl_fsm_v2: every output is packed into one word and compared per cycle.
module tb_mc_ctrl_fsm_v2;
  import mc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm_v2_if #(.ALUOP_W(3), .SRCB_W(3), .BRANCH_W(4)) bus ();

  mc_ctrl_fsm_v2 #(
    .ALUOP_W     (3),
    .SRCB_W      (3),
    .BRANCH_W    (4),
    .MEM_TIMEOUT (15)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // strb order: PC_WE, Mem_WE, IR_WE, ALUSrcA, Dst, RegIn, Reg_WE, JAL
  function automatic logic [31:0] word(input state_e st, input logic req, input logic [7:0] strb,
                                       input logic [1:0] pcsrc, input logic [2:0] srcb,
                                       input logic [2:0] aluop, input logic [3:0] br,
                                       input logic tr);
    return {5'b0, st, req, strb, pcsrc, srcb, aluop, br, tr};
  endfunction

  function automatic logic [31:0] obs();
    return {5'b0, bus.state_o, bus.mem_req, bus.PC_WE, bus.Mem_WE, bus.IR_WE, bus.ALUSrcA,
            bus.Dst, bus.RegIn, bus.Reg_WE, bus.JAL, bus.PCSrc, bus.ALUSrcB, bus.ALUop,
            bus.Branch, bus.trap};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] exp);
    #1;
    check_eq(tag, obs(), exp);
  endtask

  // Caller is in IF; completes the fetch and checks the ID_DEC cycle, leaving mem_ready low.
  task automatic fetch(input logic [31:0] ins);
    bus.mem_ready = 1'b1;
    expect_out("if_fire", word(StIf, 1'b1, 8'hA0, 2'd1, 3'd3, 3'd0, 4'd0, 1'b0));
    cyc();
    bus.instruction = ins;
    bus.mem_ready   = 1'b0;
    expect_out("id_dec", word(StIdDec, 1'b0, 8'h00, 2'd0, 3'd0, 3'd0, 4'd0, 1'b0));
    cyc();
  endtask

  task automatic expect_if_idle(input string tag);
    expect_out(tag, word(StIf, 1'b1, 8'h00, 2'd1, 3'd3, 3'd0, 4'd0, 1'b0));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.mem_ready = 1'b1;
    expect_out("rst_hold", 32'h0);
    cyc();
    reset_n = 1'b1;
    bus.mem_ready = 1'b0;
    expect_if_idle("rst_release");
  endtask

  initial begin
    // Reset held two cycles with an ADD in IR
    reset_n         = 1'b0;
    bus.instruction = 32'h0022_1820;
    bus.mem_ready   = 1'b1;
    expect_out("rst_pre", 32'h0);
    cyc();
    expect_out("rst_c1", 32'h0);
    cyc();
    expect_out("rst_c2", 32'h0);
    reset_n       = 1'b1;
    bus.mem_ready = 1'b0;

    // Fetch wait states: strobes only on the ready cycle
    for (int i = 0; i < 3; i++) begin
      expect_if_idle("if_wait");
      cyc();
    end
    fetch(32'h0022_1820);
    expect_out("ex_add", word(StExAdd, 1'b0, 8'h10, 2'd0, 3'd2, 3'd0, 4'd0, 1'b0));
    cyc();
    expect_out("wb_add", word(StWbR, 1'b0, 8'h1E, 2'd0, 3'd2, 3'd0, 4'd0, 1'b0));
    cyc();
    expect_if_idle("if_after_add");

    // LW: IF, ID_DEC, EX_MEMADDI, MEM_LW, WB_LW, IF
    fetch(32'h8C22_0004);
    expect_out("ex_lw", word(StExMemAddi, 1'b0, 8'h10, 2'd0, 3'd1, 3'd0, 4'd0, 1'b0));
    cyc();
    bus.mem_ready = 1'b1;
    expect_out("mem_lw", word(StMemLw, 1'b1, 8'h00, 2'd0, 3'd0, 3'd0, 4'd0, 1'b0));
    cyc();
    bus.mem_ready = 1'b0;
    expect_out("wb_lw", word(StWbLw, 1'b0, 8'h02, 2'd0, 3'd0, 3'd0, 4'd0, 1'b0));
    cyc();
    expect_if_idle("if_after_lw");

    // ADDI whose low bits equal the JR funct must still take the immediate path
    fetch(32'h2022_0008);
    expect_out("ex_addi", word(StExMemAddi, 1'b0, 8'h10, 2'd0, 3'd1, 3'd0, 4'd0, 1'b0));
    cyc();
    expect_out("wb_addi", word(StWbImm, 1'b0, 8'h16, 2'd0, 3'd1, 3'd0, 4'd0, 1'b0));
    cyc();
    fetch(32'h03E0_0008);
    expect_out("ex_jr", word(StExJr, 1'b0, 8'h90, 2'd1, 3'd4, 3'd0, 4'd0, 1'b0));
    cyc();
    expect_if_idle("if_after_jr");

    fetch(32'h3822_00FF);
    expect_out("ex_xori", word(StExXori, 1'b0, 8'h10, 2'd0, 3'd1, 3'd2, 4'd0, 1'b0));
    cyc();
    expect_out("wb_xori", word(StWbImm, 1'b0, 8'h16, 2'd0, 3'd1, 3'd2, 4'd0, 1'b0));
    cyc();
    fetch(32'h0022_1822);
    expect_out("ex_sub", word(StExSub, 1'b0, 8'h10, 2'd0, 3'd2, 3'd1, 4'd0, 1'b0));
    cyc();
    expect_out("wb_sub", word(StWbR, 1'b0, 8'h1E, 2'd0, 3'd2, 3'd1, 4'd0, 1'b0));
    cyc();
    fetch(32'h0022_182A);
    expect_out("ex_slt", word(StExSlt, 1'b0, 8'h10, 2'd0, 3'd2, 3'd3, 4'd0, 1'b0));
    cyc();
    expect_out("wb_slt", word(StWbR, 1'b0, 8'h1E, 2'd0, 3'd2, 3'd3, 4'd0, 1'b0));
    cyc();

    fetch(32'h1022_0003);
    expect_out("id_beq", word(StIdBr, 1'b0, 8'h00, 2'd0, 3'd0, 3'd0, 4'd0, 1'b0));
    cyc();
    expect_out("ex_beq", word(StExBeq, 1'b0, 8'h10, 2'd0, 3'd2, 3'd1, 4'd1, 1'b0));
    cyc();
    fetch(32'h1422_0003);
    expect_out("id_bne", word(StIdBr, 1'b0, 8'h00, 2'd0, 3'd0, 3'd0, 4'd0, 1'b0));
    cyc();
    expect_out("ex_bne", word(StExBne, 1'b0, 8'h10, 2'd0, 3'd2, 3'd1, 4'd2, 1'b0));
    cyc();
    fetch(32'h0800_0010);
    expect_out("id_j", word(StIdJ, 1'b0, 8'h80, 2'd2, 3'd0, 3'd0, 4'd0, 1'b0));
    cyc();
    fetch(32'h0C00_0010);
    expect_out("id_jal", word(StIdJal, 1'b0, 8'h87, 2'd2, 3'd0, 3'd0, 4'd0, 1'b0));
    cyc();

    // 15 stalled fetch cycles, then completion on the saturating cycle: no timeout
    for (int i = 0; i < 15; i++) begin
      expect_if_idle("if_long_wait");
      cyc();
    end
    fetch(32'hAC22_0004);
    expect_out("ex_sw", word(StExMemAddi, 1'b0, 8'h10, 2'd0, 3'd1, 3'd0, 4'd0, 1'b0));
    cyc();
    for (int i = 0; i < 16; i++) begin
      expect_out("sw_wait", word(StMemSw, 1'b1, 8'h00, 2'd0, 3'd0, 3'd0, 4'd0, 1'b0));
      cyc();
    end
`ifdef CTRL_TRAP_EN
    expect_out("sw_timeout", word(StTrap, 1'b0, 8'h00, 2'd0, 3'd0, 3'd0, 4'd0, 1'b1));
    cyc();
    bus.mem_ready = 1'b1;
    expect_out("trap_sticky", word(StTrap, 1'b0, 8'h00, 2'd0, 3'd0, 3'd0, 4'd0, 1'b1));
    do_reset();
`else
    for (int i = 0; i < 4; i++) begin
      expect_out("sw_wait_more", word(StMemSw, 1'b1, 8'h00, 2'd0, 3'd0, 3'd0, 4'd0, 1'b0));
      cyc();
    end
    bus.mem_ready = 1'b1;
    expect_out("sw_done", word(StMemSw, 1'b1, 8'h40, 2'd0, 3'd0, 3'd0, 4'd0, 1'b0));
    cyc();
    bus.mem_ready = 1'b0;
    expect_if_idle("if_after_sw");
`endif

    // Reset during a completing store must suppress Mem_WE
    fetch(32'hAC22_0004);
    cyc();
    do_reset();

    // Illegal opcode and illegal R-type funct
    fetch(32'hFC00_0000);
`ifdef CTRL_TRAP_EN
    expect_out("illegal_op", word(StTrap, 1'b0, 8'h00, 2'd0, 3'd0, 3'd0, 4'd0, 1'b1));
    do_reset();
`else
    expect_if_idle("illegal_op");
`endif
    fetch(32'h0000_003F);
`ifdef CTRL_TRAP_EN
    expect_out("illegal_funct", word(StTrap, 1'b0, 8'h00, 2'd0, 3'd0, 3'd0, 4'd0, 1'b1));
`else
    expect_if_idle("illegal_funct");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
